// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// default widths, the controller state type and the signed-overflow rule.
package adder_seq_pkg;

    localparam int W_DEF        = 8;
    localparam int MAXWORDS_DEF = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Two's-complement overflow: operands agree in sign but the result does not
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Command, operand, result and adder-pin bundle of the sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface adder_seq_ctrl_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_nwords;
    logic          cmd_cin;
    logic          cmd_sub;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;

    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;

    modport slave (
        input  cmd_valid, cmd_nwords, cmd_cin, cmd_sub,
        input  in_valid, in_a, in_b,
        input  out_ready,
        input  add_sum, add_cout,
        output cmd_ready, in_ready,
        output out_valid, out_sum, out_last, out_cout, out_ovf,
        output add_a, add_b, add_cin
    );

    modport master (
        output cmd_valid, cmd_nwords, cmd_cin, cmd_sub,
        output in_valid, in_a, in_b,
        output out_ready,
        output add_sum, add_cout,
        input  cmd_ready, in_ready,
        input  out_valid, out_sum, out_last, out_cout, out_ovf,
        input  add_a, add_b, add_cin
    );
endinterface

// File: rtl/adder_seq_ctrl_outreg.sv
// Single-entry result register with valid/ready handshake; a pop and a load
// in the same cycle pass straight through so the stream keeps one word per cycle.
module adder_seq_outreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d_sum,
    input  logic         d_last,
    input  logic         d_cout,
    input  logic         d_ovf,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_sum,
    output logic         out_last,
    output logic         out_cout,
    output logic         out_ovf
);

    // Payload only changes on load, so it holds stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= d_sum;
            out_last  <= d_last;
            out_cout  <= d_cout;
            out_ovf   <= d_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams LSB-first word pairs through an
// external W-bit adder, chaining the carry and reporting final carry/borrow and overflow.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MAXWORDS = MAXWORDS_DEF,
    parameter int CW       = $clog2(MAXWORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_seq_ctrl_if.slave bus
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nwords_q;
    logic          carry_q;
    logic          sub_q;

    logic cmd_ready_c;
    logic in_ready_c;
    logic cmd_fire;
    logic in_fire;
    logic is_last;
    logic d_cout;
    logic d_ovf;

    // Subtraction is A + ~B + ~borrow, so only the B word and carry sense flip
    assign bus.add_a   = bus.in_a;
    assign bus.add_b   = sub_q ? ~bus.in_b : bus.in_b;
    assign bus.add_cin = carry_q;

    assign is_last  = (cnt == nwords_q);
    assign cmd_fire = bus.cmd_valid && cmd_ready_c;
    assign in_fire  = bus.in_valid && in_ready_c;
    assign d_cout   = is_last && (sub_q ? ~bus.add_cout : bus.add_cout);
    assign d_ovf    = is_last && signed_ovf(bus.add_a[W-1], bus.add_b[W-1], bus.add_sum[W-1]);

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.in_ready  = in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        in_ready_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready_c = !bus.out_valid || bus.out_ready;
                if (bus.in_valid && in_ready_c && is_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter restarts on the last word so it never runs past nwords_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            nwords_q <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
        end else if (cmd_fire) begin
            cnt      <= '0;
            nwords_q <= bus.cmd_nwords;
            sub_q    <= bus.cmd_sub;
            carry_q  <= bus.cmd_sub ? ~bus.cmd_cin : bus.cmd_cin;
        end else if (in_fire) begin
            cnt      <= is_last ? '0 : cnt + 1'b1;
            carry_q  <= bus.add_cout;
        end
    end

    adder_seq_outreg #(
        .W(W)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (in_fire),
        .d_sum     (bus.add_sum),
        .d_last    (is_last),
        .d_cout    (d_cout),
        .d_ovf     (d_ovf),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_sum   (bus.out_sum),
        .out_last  (bus.out_last),
        .out_cout  (bus.out_cout),
        .out_ovf   (bus.out_ovf)
    );

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: whole-number reference model feeds a queue,
// an independent monitor pops and compares every accepted result word.
module tb_adder_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic bp_rand;
    logic rnd_ready;
    logic ready_manual;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    adder_seq_ctrl_if #(.W(W), .CW(CW)) bus ();

    adder_seq_ctrl #(
        .W        (W),
        .MAXWORDS (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stand-in for the external 8-bit adder
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};
    assign bus.out_ready = bp_rand ? rnd_ready : ready_manual;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: treat the operands as (nw+1)*8-bit integers and do the whole op at once
    task automatic push_model(input int nw, input bit cin, input bit sub,
                              input logic [127:0] a, input logic [127:0] b);
        int                 bits;
        logic [135:0]       mask, ua, ub, uc, r;
        logic signed [135:0] sa, sbv, sc, res, lim;
        logic               cout, ovf;
        exp_t               e;
        bits = 8 * (nw + 1);
        mask = (136'd1 << bits) - 136'd1;
        ua   = {8'd0, a} & mask;
        ub   = {8'd0, b} & mask;
        uc   = 136'(cin);
        r    = sub ? (ua - ub - uc) : (ua + ub + uc);
        cout = r[bits];
        sa   = $signed(ua);
        sbv  = $signed(ub);
        sc   = $signed(uc);
        if (ua[bits-1]) sa = sa - (136'sd1 <<< bits);
        if (ub[bits-1]) sbv = sbv - (136'sd1 <<< bits);
        res  = sub ? (sa - sbv - sc) : (sa + sbv + sc);
        lim  = 136'sd1 <<< (bits - 1);
        ovf  = (res > (lim - 136'sd1)) || (res < -lim);
        for (int k = 0; k <= nw; k++) begin
            e.sum  = r[8*k +: 8];
            e.last = (k == nw);
            e.cout = (k == nw) ? cout : 1'b0;
            e.ovf  = (k == nw) ? ovf : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic send_cmd(input int nw, input bit cin, input bit sub);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_nwords = 4'(nw);
        bus.cmd_cin    = cin;
        bus.cmd_sub    = sub;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] pb, output logic pc);
        bit ok;
        ok = 1'b0;
        pb = '0;
        pc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                pb = bus.add_b;
                pc = bus.add_cin;
                break;
            end
        end
        if (!ok) check("word_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int nw, input bit cin, input bit sub,
                                 input logic [127:0] a, input logic [127:0] b, input bit gaps);
        logic [7:0] pb;
        logic       pc;
        push_model(nw, cin, sub, a, b);
        send_cmd(nw, cin, sub);
        for (int k = 0; k <= nw; k++) begin
            send_word(a[8*k +: 8], b[8*k +: 8], pb, pc);
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            if (gaps) #1;
        end
    endtask

    // Monitor: every accepted result word is compared against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("out_sum", 32'(bus.out_sum), 32'(e.sum));
                check("out_last", 32'(bus.out_last), 32'(e.last));
                check("out_cout", 32'(bus.out_cout), 32'(e.cout));
                check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        logic [7:0] pb;
        logic       pc;
        logic [7:0] held;
        bit         seen;
        n_pass         = 0;
        n_total        = 0;
        bp_rand        = 1'b0;
        ready_manual   = 1'b1;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_nwords = '0;
        bus.cmd_cin    = 1'b0;
        bus.cmd_sub    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;

        #12;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(bus.out_sum), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_out_cout", 32'(bus.out_cout), 32'd0);
        checkOutput("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add FF+01 with one-cycle latency
        push_model(0, 1'b0, 1'b0, 128'hFF, 128'h01);
        send_cmd(0, 1'b0, 1'b0);
        send_word(8'hFF, 8'h01, pb, pc);
        checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("single_sum", 32'(bus.out_sum), 32'h00);
        checkOutput("single_cout", 32'(bus.out_cout), 32'd1);

        // Two-word chain: carry from word 1 must reach add_cin on word 2
        push_model(1, 1'b0, 1'b0, 128'h01FF, 128'h0001);
        send_cmd(1, 1'b0, 1'b0);
        send_word(8'hFF, 8'h01, pb, pc);
        checkOutput("chain_cin_w1", 32'(pc), 32'd0);
        send_word(8'h01, 8'h00, pb, pc);
        checkOutput("chain_cin_w2", 32'(pc), 32'd1);

        // Subtract 00-01 and 80-01, then signed overflow on add 7F+01
        push_model(0, 1'b0, 1'b1, 128'h00, 128'h01);
        send_cmd(0, 1'b0, 1'b1);
        send_word(8'h00, 8'h01, pb, pc);
        checkOutput("sub_add_b", 32'(pb), 32'hFE);
        checkOutput("sub_add_cin", 32'(pc), 32'd1);
        applyStimulus(0, 1'b0, 1'b1, 128'h80, 128'h01, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 128'h7F, 128'h01, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 128'h1234, 128'h1234, 1'b0);

        // Backpressure: hold the first of three results for three cycles
        repeat (3) @(posedge clk);
        #1;
        ready_manual = 1'b0;
        fork
            applyStimulus(2, 1'b0, 1'b0, 128'h123456, 128'h0F0F0F, 1'b0);
            begin
                seen = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                checkOutput("bp_first_valid", 32'(seen), 32'd1);
                held = bus.out_sum;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    checkOutput("bp_sum_hold", 32'(bus.out_sum), 32'(held));
                    checkOutput("bp_valid_hold", 32'(bus.out_valid), 32'd1);
                end
                @(posedge clk);
                #1;
                ready_manual = 1'b1;
            end
        join

        // Reset in the middle of a 4-word op discards everything pending
        repeat (4) @(posedge clk);
        #1;
        ready_manual = 1'b0;
        send_cmd(3, 1'b0, 1'b0);
        send_word(8'h11, 8'h22, pb, pc);
        checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        ready_manual = 1'b1;
        push_model(0, 1'b0, 1'b0, 128'h10, 128'h20);
        send_cmd(0, 1'b0, 1'b0);
        send_word(8'h10, 8'h20, pb, pc);
        checkOutput("post_rst_sum", 32'(bus.out_sum), 32'h30);

        // Maximum length op, then randomized traffic with random backpressure
        applyStimulus(15, 1'b1, 1'b0, {16{8'hFF}}, 128'h0, 1'b0);
        applyStimulus(15, 1'b0, 1'b1, 128'h0, 128'h1, 1'b0);
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end
        bp_rand = 1'b0;
        ready_manual = 1'b1;
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
